// File: rtl/lcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lcd_ctrl
// Purpose  : 8x8 grayscale image controller. Loads the image from IROM into a
//            64-byte buffer, runs 2x2-window edit commands around a movable
//            operation point, then streams the buffer to IRAM and flags done.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cmd,
  input  logic       cmd_valid,
  output logic       IROM_rd,
  output logic [5:0] IROM_A,
  input  logic [7:0] IROM_Q,
  output logic       IRAM_valid,
  output logic [7:0] IRAM_D,
  output logic [5:0] IRAM_A,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_IDLE  = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] CMD_WRITE = 4'd0;
  localparam logic [3:0] CMD_UP    = 4'd1;
  localparam logic [3:0] CMD_DOWN  = 4'd2;
  localparam logic [3:0] CMD_LEFT  = 4'd3;
  localparam logic [3:0] CMD_RIGHT = 4'd4;
  localparam logic [3:0] CMD_MAX   = 4'd5;
  localparam logic [3:0] CMD_MIN   = 4'd6;
  localparam logic [3:0] CMD_AVG   = 4'd7;
  localparam logic [3:0] CMD_CCW   = 4'd8;
  localparam logic [3:0] CMD_CW    = 4'd9;
  localparam logic [3:0] CMD_MIRX  = 4'd10;
  localparam logic [3:0] CMD_MIRY  = 4'd11;

  localparam logic [2:0] PT_MIN    = 3'd1;
  localparam logic [2:0] PT_MAX    = 3'd7;
  localparam logic [2:0] PT_INIT   = 3'd4;
  localparam logic [5:0] ADDR_LAST = 6'd63;

  state_t      state_q, state_d;
  logic        rom_rd_q, rom_rd_d;
  logic [5:0]  rom_a_q, rom_a_d;
  logic        ram_valid_q, ram_valid_d;
  logic [5:0]  ram_a_q, ram_a_d;
  logic [7:0]  ram_d_q, ram_d_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [2:0]  px_q, px_d;
  logic [2:0]  py_q, py_d;
  logic [3:0]  cmd_q, cmd_d;

  logic [7:0]  buf_q [64];

  // Window geometry: P0 top-left, P1 top-right, P2 bottom-left, P3 bottom-right
  logic [2:0]  px_m1, py_m1;
  logic [5:0]  win_a [4];
  logic [7:0]  win_p [4];
  logic [7:0]  win_n [4];
  logic        win_cmd;
  logic        win_we;
  logic        load_we;

  logic [7:0]  max01, max23, win_max;
  logic [7:0]  min01, min23, win_min;
  logic [9:0]  win_sum;
  logic [7:0]  win_avg;
  logic [5:0]  ram_a_nxt;

  assign px_m1     = px_q - 3'd1;
  assign py_m1     = py_q - 3'd1;
  assign win_a[0]  = {py_m1, px_m1};
  assign win_a[1]  = {py_m1, px_q};
  assign win_a[2]  = {py_q,  px_m1};
  assign win_a[3]  = {py_q,  px_q};

  assign win_p[0]  = buf_q[win_a[0]];
  assign win_p[1]  = buf_q[win_a[1]];
  assign win_p[2]  = buf_q[win_a[2]];
  assign win_p[3]  = buf_q[win_a[3]];

  assign max01     = (win_p[0] > win_p[1]) ? win_p[0] : win_p[1];
  assign max23     = (win_p[2] > win_p[3]) ? win_p[2] : win_p[3];
  assign win_max   = (max01 > max23) ? max01 : max23;
  assign min01     = (win_p[0] < win_p[1]) ? win_p[0] : win_p[1];
  assign min23     = (win_p[2] < win_p[3]) ? win_p[2] : win_p[3];
  assign win_min   = (min01 < min23) ? min01 : min23;
  assign win_sum   = {2'b00, win_p[0]} + {2'b00, win_p[1]}
                   + {2'b00, win_p[2]} + {2'b00, win_p[3]};
  assign win_avg   = 8'(win_sum >> 2);

  assign ram_a_nxt = ram_a_q + 6'd1;

  // New window contents for the latched command; all sources are pre-command
  always_comb begin
    win_n   = win_p;
    win_cmd = 1'b0;
    case (cmd_q)
      CMD_MAX: begin
        win_cmd  = 1'b1;
        win_n[0] = win_max; win_n[1] = win_max;
        win_n[2] = win_max; win_n[3] = win_max;
      end
      CMD_MIN: begin
        win_cmd  = 1'b1;
        win_n[0] = win_min; win_n[1] = win_min;
        win_n[2] = win_min; win_n[3] = win_min;
      end
      CMD_AVG: begin
        win_cmd  = 1'b1;
        win_n[0] = win_avg; win_n[1] = win_avg;
        win_n[2] = win_avg; win_n[3] = win_avg;
      end
      CMD_CCW: begin
        win_cmd  = 1'b1;
        win_n[0] = win_p[1]; win_n[1] = win_p[3];
        win_n[3] = win_p[2]; win_n[2] = win_p[0];
      end
      CMD_CW: begin
        win_cmd  = 1'b1;
        win_n[0] = win_p[2]; win_n[1] = win_p[0];
        win_n[3] = win_p[1]; win_n[2] = win_p[3];
      end
      CMD_MIRX: begin
        win_cmd  = 1'b1;
        win_n[0] = win_p[2]; win_n[2] = win_p[0];
        win_n[1] = win_p[3]; win_n[3] = win_p[1];
      end
      CMD_MIRY: begin
        win_cmd  = 1'b1;
        win_n[0] = win_p[1]; win_n[1] = win_p[0];
        win_n[2] = win_p[3]; win_n[3] = win_p[2];
      end
      default: begin
        win_cmd = 1'b0;
      end
    endcase
  end

  // Next-state and next-output logic for the load/command/write sequencer
  always_comb begin
    state_d     = state_q;
    rom_rd_d    = rom_rd_q;
    rom_a_d     = rom_a_q;
    ram_valid_d = ram_valid_q;
    ram_a_d     = ram_a_q;
    ram_d_d     = ram_d_q;
    busy_d      = busy_q;
    done_d      = done_q;
    px_d        = px_q;
    py_d        = py_q;
    cmd_d       = cmd_q;
    load_we     = 1'b0;
    win_we      = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (!rom_rd_q) begin
          // First cycle out of reset: present address 0
          rom_rd_d = 1'b1;
          rom_a_d  = 6'd0;
        end else begin
          load_we = 1'b1;
          if (rom_a_q == ADDR_LAST) begin
            rom_rd_d = 1'b0;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
          end else begin
            rom_a_d = rom_a_q + 6'd1;
          end
        end
      end
      S_IDLE: begin
        if (cmd_valid) begin
          cmd_d   = cmd;
          busy_d  = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
        case (cmd_q)
          CMD_WRITE: begin
            // Present pixel 0 right away so the stream is 64 back-to-back cycles
            busy_d      = 1'b1;
            state_d     = S_WRITE;
            ram_valid_d = 1'b1;
            ram_a_d     = 6'd0;
            ram_d_d     = buf_q[0];
          end
          CMD_UP:    if (py_q > PT_MIN) py_d = py_q - 3'd1;
          CMD_DOWN:  if (py_q < PT_MAX) py_d = py_q + 3'd1;
          CMD_LEFT:  if (px_q > PT_MIN) px_d = px_q - 3'd1;
          CMD_RIGHT: if (px_q < PT_MAX) px_d = px_q + 3'd1;
          default:   win_we = win_cmd;
        endcase
      end
      S_WRITE: begin
        if (ram_a_q == ADDR_LAST) begin
          ram_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = S_DONE;
        end else begin
          ram_a_d = ram_a_nxt;
          ram_d_d = buf_q[ram_a_nxt];
        end
      end
      S_DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  // Sequencer state, operation point and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_LOAD;
      rom_rd_q    <= 1'b0;
      rom_a_q     <= 6'd0;
      ram_valid_q <= 1'b0;
      ram_a_q     <= 6'd0;
      ram_d_q     <= 8'd0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      px_q        <= PT_INIT;
      py_q        <= PT_INIT;
      cmd_q       <= 4'd0;
    end else begin
      state_q     <= state_d;
      rom_rd_q    <= rom_rd_d;
      rom_a_q     <= rom_a_d;
      ram_valid_q <= ram_valid_d;
      ram_a_q     <= ram_a_d;
      ram_d_q     <= ram_d_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      px_q        <= px_d;
      py_q        <= py_d;
      cmd_q       <= cmd_d;
    end
  end

  // Image buffer: filled from ROM during load, rewritten a window at a time
  always_ff @(posedge clk) begin
    if (reset) begin
      if (load_we) begin
        buf_q[rom_a_q] <= IROM_Q;
      end
      if (win_we) begin
        buf_q[win_a[0]] <= win_n[0];
        buf_q[win_a[1]] <= win_n[1];
        buf_q[win_a[2]] <= win_n[2];
        buf_q[win_a[3]] <= win_n[3];
      end
    end
  end

  assign IROM_rd    = rom_rd_q;
  assign IROM_A     = rom_a_q;
  assign IRAM_valid = ram_valid_q;
  assign IRAM_A     = ram_a_q;
  assign IRAM_D     = ram_d_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_ctrl
// Purpose  : Self-checking bench for lcd_ctrl with an image-level reference
//            model, behavioural IROM and a log of IRAM writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_ctrl;

  logic       clk       = 1'b0;
  logic       reset     = 1'b0;
  logic [3:0] cmd       = 4'd0;
  logic       cmd_valid = 1'b0;
  logic       IROM_rd;
  logic [5:0] IROM_A;
  logic [7:0] IROM_Q    = 8'd0;
  logic       IRAM_valid;
  logic [7:0] IRAM_D;
  logic [5:0] IRAM_A;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  rom [64];
  logic [13:0] wq [$];     // {addr, data} of every RAM write, in order
  int          img [64];   // reference image
  int          px, py;     // reference operation point

  lcd_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .IROM_rd    (IROM_rd),
    .IROM_A     (IROM_A),
    .IROM_Q     (IROM_Q),
    .IRAM_valid (IRAM_valid),
    .IRAM_D     (IRAM_D),
    .IRAM_A     (IRAM_A),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // ROM answers on the falling edge
  always @(negedge clk) if (IROM_rd) IROM_Q <= rom[IROM_A];

  // RAM writes on the falling edge; record them
  always @(negedge clk) if (IRAM_valid) wq.push_back({IRAM_A, IRAM_D});

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int wdata(input int a);
    if (a < wq.size()) return int'(wq[a][7:0]);
    return -1;
  endfunction

  task automatic rom_random();
    for (int i = 0; i < 64; i++) rom[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic rom_window();
    rom_random();
    rom[27] = 8'd10; rom[28] = 8'd20; rom[35] = 8'd30; rom[36] = 8'd41;
  endtask

  // Image-level reference: apply one edit/shift command
  task automatic model_apply(input int c);
    int a[4]; int v[4]; int nv[4]; int s; int mx; int mn;
    a[0] = (py - 1) * 8 + (px - 1);
    a[1] = a[0] + 1;
    a[2] = a[0] + 8;
    a[3] = a[0] + 9;
    s = 0; mx = 0; mn = 255;
    for (int k = 0; k < 4; k++) begin
      v[k] = img[a[k]];
      nv[k] = v[k];
      s += v[k];
      if (v[k] > mx) mx = v[k];
      if (v[k] < mn) mn = v[k];
    end
    case (c)
      1: if (py > 1) py--;
      2: if (py < 7) py++;
      3: if (px > 1) px--;
      4: if (px < 7) px++;
      5: nv = '{mx, mx, mx, mx};
      6: nv = '{mn, mn, mn, mn};
      7: nv = '{s / 4, s / 4, s / 4, s / 4};
      8: nv = '{v[1], v[3], v[0], v[2]};
      9: nv = '{v[2], v[0], v[3], v[1]};
      10: nv = '{v[2], v[3], v[0], v[1]};
      11: nv = '{v[1], v[0], v[3], v[2]};
      default: ;
    endcase
    for (int k = 0; k < 4; k++) img[a[k]] = nv[k];
  endtask

  task automatic do_reset();
    int n;
    @(negedge clk);
    reset = 1'b0;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 1);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_irom_rd", 32'(IROM_rd), 0);
    check_eq("rst_irom_a", 32'(IROM_A), 0);
    check_eq("rst_iram_valid", 32'(IRAM_valid), 0);
    check_eq("rst_iram_a", 32'(IRAM_A), 0);
    check_eq("rst_iram_d", 32'(IRAM_D), 0);
    for (int i = 0; i < 64; i++) img[i] = int'(rom[i]);
    px = 4; py = 4;
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("load_first_rd", 32'(IROM_rd), 1);
    check_eq("load_first_a", 32'(IROM_A), 0);
    n = 1;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("load_cycles", n, 65);
    check_eq("load_rd_dropped", 32'(IROM_rd), 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) check_eq("idle_timeout", 32'(busy), 0);
  endtask

  task automatic send_cmd(input int c, input bit hold);
    wait_idle();
    cmd = 4'(c);
    cmd_valid = 1'b1;
    @(negedge clk);
    check_eq("busy_after_accept", 32'(busy), 1);
    if (hold) begin
      @(negedge clk);
      check_eq("busy_after_exec", 32'(busy), 0);
    end
    cmd_valid = 1'b0;
    cmd = 4'($urandom_range(0, 15));
    model_apply(c);
  endtask

  task automatic start_write();
    wq.delete();
    wait_idle();
    cmd = 4'd0;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic do_write();
    int n;
    start_write();
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("write_cycles", n, 65);
    check_eq("done_valid_low", 32'(IRAM_valid), 0);
    @(negedge clk);
    check_eq("write_count", wq.size(), 64);
    for (int i = 0; i < 64; i++) begin
      if (i < wq.size()) begin
        check_eq($sformatf("wr_addr[%0d]", i), 32'(wq[i][13:8]), i);
        check_eq($sformatf("wr_data[%0d]", i), 32'(wq[i][7:0]), img[i]);
      end
    end
  endtask

  task automatic done_sticky();
    cmd_valid = 1'b1;
    repeat (6) begin
      cmd = 4'($urandom_range(0, 15));
      @(negedge clk);
      check_eq("sticky_done", 32'(done), 1);
      check_eq("sticky_busy", 32'(busy), 1);
      check_eq("sticky_valid", 32'(IRAM_valid), 0);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic check_window(input string tag, input int e0, input int e1, input int e2, input int e3);
    check_eq({tag, "_p0"}, wdata(27), e0);
    check_eq({tag, "_p1"}, wdata(28), e1);
    check_eq({tag, "_p2"}, wdata(35), e2);
    check_eq({tag, "_p3"}, wdata(36), e3);
  endtask

  initial begin
    int wcmd [8];
    int wexp [8][4];
    int mx;
    wcmd = '{7, 5, 6, 8, 9, 10, 11, 15};
    wexp = '{'{25, 25, 25, 25}, '{41, 41, 41, 41}, '{10, 10, 10, 10},
             '{20, 41, 10, 30}, '{30, 10, 41, 20}, '{30, 41, 10, 20},
             '{20, 10, 41, 30}, '{10, 20, 30, 41}};

    // Identity image straight through
    for (int i = 0; i < 64; i++) rom[i] = 8'(i);
    do_reset();
    do_write();
    for (int i = 0; i < 64; i += 21) check_eq($sformatf("ident[%0d]", i), wdata(i), i);
    done_sticky();

    // Clamp to top-left, then max over addresses 0,1,8,9
    rom_random();
    do_reset();
    repeat (5) send_cmd(3, 1'b0);
    repeat (5) send_cmd(1, 1'b0);
    send_cmd(5, 1'b0);
    mx = 0;
    for (int k = 0; k < 4; k++) begin
      int a;
      a = (k / 2) * 8 + (k % 2);
      if (int'(rom[a]) > mx) mx = int'(rom[a]);
    end
    do_write();
    check_eq("tl_max_0", wdata(0), mx);
    check_eq("tl_max_9", wdata(9), mx);
    check_eq("tl_untouched_2", wdata(2), int'(rom[2]));

    // Clamp to bottom-right, then min
    rom_random();
    do_reset();
    repeat (5) send_cmd(4, 1'b0);
    repeat (5) send_cmd(2, 1'b0);
    send_cmd(6, 1'b0);
    do_write();

    // Fixed window at the reset point for every window operation
    for (int t = 0; t < 8; t++) begin
      rom_window();
      do_reset();
      send_cmd(wcmd[t], 1'b0);
      do_write();
      check_window($sformatf("win_cmd%0d", wcmd[t]), wexp[t][0], wexp[t][1], wexp[t][2], wexp[t][3]);
    end

    // cmd_valid held across the busy cycle executes only once
    rom_window();
    do_reset();
    send_cmd(8, 1'b1);
    do_write();
    check_window("hold_ccw", 20, 41, 10, 30);

    // Random command sequences
    for (int r = 0; r < 4; r++) begin
      rom_random();
      do_reset();
      repeat (30) send_cmd($urandom_range(1, 15), 1'b0);
      do_write();
    end

    // Reset in the middle of the write stream
    rom_random();
    do_reset();
    start_write();
    repeat (20) @(posedge clk);
    #1;
    check_eq("mid_write_valid", 32'(IRAM_valid), 1);
    check_eq("mid_write_done", 32'(done), 0);
    rom_random();
    do_reset();
    check_eq("reload_done_low", 32'(done), 0);
    send_cmd(9, 1'b0);
    do_write();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
